dp_ram_pipe: RTL and testbench

DP_RAM_PIPE -- requirements
Module: dp_ram_pipe

---
 rtl/dp_ram_pkg.sv | 13 +
 rtl/dp_ram_mem.sv | 39 +++
 rtl/dp_ram_pipe.sv | 162 ++++++++++++++++
 tb/tb_dp_ram_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// rtl/dp_ram_pkg.sv - shared types and constants for the pipelined dual-port RAM
// Contents: FSM state type and encodings (INIT/RUN), read-during-write mode constants.
package dp_ram_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_INIT = 1'b0;
   localparam state_t ST_RUN  = 1'b1;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

endpackage

// File: rtl/dp_ram_mem.sv
// rtl/dp_ram_mem.sv - storage array with one byte-enabled write port and one synchronous read port
// Ports: clk; we/waddr/wdata/wbe write port; re/raddr read request; rdata registered read word.
// No reset: contents and rdata are only defined once written / read.
module dp_ram_mem #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wbe,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_W-1:0]     rdata
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int NB    = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Non-blocking read and write in one block: a same-address read sees the
   // pre-write word (read-before-write).
   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < NB; k++) begin
            if (wbe[k]) begin
               mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
         end
      end
      // rdata changes only on an accepted read, so it holds between reads.
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/dp_ram_pipe.sv
// rtl/dp_ram_pipe.sv - dual-port RAM with init sweep, byte enables, selectable read latency and RDW mode
// Ports: clk, rst (async, active low), en global enable;
//        wr_en/wr_addr/wr_data/wr_be write request; rd_en/rd_addr read request;
//        rd_data/rd_valid/collision read result; ready high after the init sweep.
module dp_ram_pipe
   import dp_ram_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 5,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = RDW_OLD
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  collision,
   output logic                  ready
);

   localparam int NB = DATA_W / 8;

   if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
      $error("dp_ram_pipe: DATA_W must be a multiple of 8 and at least 8");
   end
   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("dp_ram_pipe: RD_LATENCY must be 1 or 2");
   end

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;

   logic              wr_acc;
   logic              rd_acc;
   logic              collide_now;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [NB-1:0]     mem_wbe;
   logic [DATA_W-1:0] mem_rdata;

   logic              v1;
   logic              col1;
   logic              have1;
   logic [DATA_W-1:0] fwd_data1;
   logic [NB-1:0]     fwd_be1;
   logic [DATA_W-1:0] d1;

   assign ready       = (state == ST_RUN);
   assign wr_acc      = en & wr_en & ready;
   assign rd_acc      = en & rd_en & ready;
   assign collide_now = rd_acc & wr_acc & (rd_addr == wr_addr);

   // Init sweep: one word zeroed per cycle, RUN entered after the last address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_INIT;
         clr_cnt <= '0;
      end else if (state == ST_INIT) begin
         clr_cnt <= clr_cnt + ADDR_W'(1);
         if (&clr_cnt) begin
            state <= ST_RUN;
         end
      end
   end

   // The sweep owns the write port during INIT; user writes are locked out by ready.
   always_comb begin
      mem_we    = wr_acc;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      mem_wbe   = wr_be;
      if (state == ST_INIT) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt;
         mem_wdata = '0;
         mem_wbe   = '1;
      end
   end

   dp_ram_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .wbe   (mem_wbe),
      .re    (rd_acc),
      .raddr (rd_addr),
      .rdata (mem_rdata)
   );

   // Stage 1 runs alongside the array read. In new-data mode a colliding write's
   // enabled bytes are remembered and patched over the pre-write word. The
   // forwarding fields only load on an accepted read so d1 holds with the array output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1        <= 1'b0;
         col1      <= 1'b0;
         have1     <= 1'b0;
         fwd_data1 <= '0;
         fwd_be1   <= '0;
      end else begin
         v1   <= rd_acc;
         col1 <= collide_now;
         if (rd_acc) begin
            have1     <= 1'b1;
            fwd_data1 <= wr_data;
            fwd_be1   <= (RDW_MODE == RDW_NEW && collide_now) ? wr_be : '0;
         end
      end
   end

   // have1 masks the unreset array output until the first read since reset.
   always_comb begin
      d1 = have1 ? mem_rdata : '0;
      for (int k = 0; k < NB; k++) begin
         if (fwd_be1[k]) begin
            d1[8*k +: 8] = fwd_data1[8*k +: 8];
         end
      end
   end

   if (RD_LATENCY == 1) begin : g_lat1
      assign rd_valid  = v1;
      assign collision = col1;
      assign rd_data   = d1;
   end else begin : g_lat2
      logic              v2;
      logic              col2;
      logic [DATA_W-1:0] d2;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            v2   <= 1'b0;
            col2 <= 1'b0;
            d2   <= '0;
         end else begin
            v2   <= v1;
            col2 <= col1;
            if (v1) begin
               d2 <= d1;
            end
         end
      end

      assign rd_valid  = v2;
      assign collision = col2;
      assign rd_data   = d2;
   end

endmodule

// File: tb/tb_dp_ram_pipe.sv
// tb/tb_dp_ram_pipe.sv - directed table-driven bench for dp_ram_pipe (latency 1 / old-data and latency 2 / new-data)
module tb_dp_ram_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic        rd_en;
   logic [4:0]  rd_addr;

   logic [15:0] rd_data0, rd_data1;
   logic        rd_valid0, rd_valid1;
   logic        collision0, collision1;
   logic        ready0, ready1;

   int          n_cmp = 0;
   int          n_bad = 0;

   logic [15:0] model [32];
   logic [15:0] last0, last1;

   always #5 clk = ~clk;

   dp_ram_pipe #(.DATA_W(16), .ADDR_W(5), .RD_LATENCY(1), .RDW_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .collision(collision0), .ready(ready0)
   );

   dp_ram_pipe #(.DATA_W(16), .ADDR_W(5), .RD_LATENCY(2), .RDW_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .collision(collision1), .ready(ready1)
   );

   typedef struct {
      logic        en;
      logic        wr;
      logic [4:0]  wa;
      logic [15:0] wd;
      logic [1:0]  wbe;
      logic        rd;
      logic [4:0]  ra;
      logic        vld;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        col;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      en      = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      wr_be   = '0;
      rd_addr = '0;
   endtask

   // Counts rising edges from here until each DUT reports ready (bounded).
   task automatic wait_ready(input string tag);
      int   e0 = 0;
      int   e1 = 0;
      logic vseen = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (rd_valid0 || rd_valid1) vseen = 1'b1;
         if (ready0 && e0 == 0) e0 = i;
         if (ready1 && e1 == 0) e1 = i;
         if (e0 != 0 && e1 != 0) break;
      end
      check({tag, " ready0 edge"}, 32'(e0), 32'd32);
      check({tag, " ready1 edge"}, 32'(e1), 32'd32);
      check({tag, " no rd_valid in init"}, 32'(vseen), 32'd0);
   endtask

   // Back-to-back reads of addresses 0..n-1; every cycle checks both pipelines.
   task automatic read_stream(input string tag, input int n);
      for (int c = 0; c <= n; c++) begin
         if (c < n) begin
            en      = 1'b1;
            rd_en   = 1'b1;
            rd_addr = c[4:0];
         end else begin
            idle();
         end
         @(posedge clk); #1;
         check($sformatf("%s c%0d valid0", tag, c), 32'(rd_valid0), 32'(c < n));
         if (c < n) begin
            check($sformatf("%s c%0d data0", tag, c), 32'(rd_data0), 32'(model[c]));
            last0 = model[c];
         end
         check($sformatf("%s c%0d valid1", tag, c), 32'(rd_valid1), 32'(c >= 1));
         if (c >= 1) begin
            check($sformatf("%s c%0d data1", tag, c), 32'(rd_data1), 32'(model[c-1]));
            last1 = model[c-1];
         end
      end
      idle();
   endtask

   initial begin
      logic vseen;

      rst = 1'b0;
      idle();
      for (int a = 0; a < 32; a++) model[a] = 16'h0000;
      last0 = 16'h0000;
      last1 = 16'h0000;

      // Reset state
      @(posedge clk); @(negedge clk);
      check("reset ready0", 32'(ready0), 32'd0);
      check("reset ready1", 32'(ready1), 32'd0);
      check("reset valid0", 32'(rd_valid0), 32'd0);
      check("reset valid1", 32'(rd_valid1), 32'd0);
      check("reset data0", 32'(rd_data0), 32'd0);
      check("reset data1", 32'(rd_data1), 32'd0);
      check("reset col0", 32'(collision0), 32'd0);
      check("reset col1", 32'(collision1), 32'd0);

      // Release; user traffic during INIT must be ignored.
      rst     = 1'b1;
      en      = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 16'hFFFF;
      wr_be   = 2'b11;
      rd_en   = 1'b1;
      rd_addr = 5'd5;
      wait_ready("boot");
      idle();

      read_stream("zero", 32);

      // Directed vectors; memory model is all-zero at this point.
      tbl[0]  = '{1'b1, 1'b1, 5'd3,  16'hA55A, 2'b11, 1'b0, 5'd0,  1'b0, 16'h0000, 16'h0000, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd3,  1'b1, 16'hA55A, 16'hA55A, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 5'd7,  16'h1234, 2'b11, 1'b0, 5'd0,  1'b0, 16'h0000, 16'h0000, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 5'd7,  16'hFFFF, 2'b01, 1'b0, 5'd0,  1'b0, 16'h0000, 16'h0000, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd7,  1'b1, 16'h12FF, 16'h12FF, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 5'd9,  16'h0001, 2'b11, 1'b0, 5'd0,  1'b0, 16'h0000, 16'h0000, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 5'd9,  16'h00BB, 2'b11, 1'b1, 5'd9,  1'b1, 16'h0001, 16'h00BB, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd9,  1'b1, 16'h00BB, 16'h00BB, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 5'd9,  16'hFFFF, 2'b00, 1'b1, 5'd9,  1'b1, 16'h00BB, 16'h00BB, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 5'd10, 16'hCAFE, 2'b10, 1'b1, 5'd9,  1'b1, 16'h00BB, 16'h00BB, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd10, 1'b1, 16'hCA00, 16'hCA00, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 5'd3,  16'h1111, 2'b11, 1'b1, 5'd3,  1'b0, 16'h0000, 16'h0000, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd3,  1'b1, 16'hA55A, 16'hA55A, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 5'd31, 16'hBEEF, 2'b01, 1'b1, 5'd31, 1'b1, 16'h0000, 16'h00EF, 1'b1};
      tbl[14] = '{1'b1, 1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd31, 1'b1, 16'h00EF, 16'h00EF, 1'b0};
      tbl[15] = '{1'b1, 1'b1, 5'd0,  16'h5A00, 2'b10, 1'b1, 5'd0,  1'b1, 16'h0000, 16'h5A00, 1'b1};

      for (int i = 0; i < 16; i++) begin
         en      = tbl[i].en;
         wr_en   = tbl[i].wr;
         wr_addr = tbl[i].wa;
         wr_data = tbl[i].wd;
         wr_be   = tbl[i].wbe;
         rd_en   = tbl[i].rd;
         rd_addr = tbl[i].ra;
         @(posedge clk); #1;
         idle();
         if (tbl[i].vld) last0 = tbl[i].d0;
         check($sformatf("vec%0d valid0", i), 32'(rd_valid0), 32'(tbl[i].vld));
         check($sformatf("vec%0d data0", i), 32'(rd_data0), 32'(last0));
         check($sformatf("vec%0d col0", i), 32'(collision0), 32'(tbl[i].vld & tbl[i].col));
         check($sformatf("vec%0d early valid1", i), 32'(rd_valid1), 32'd0);
         @(posedge clk); #1;
         if (tbl[i].vld) last1 = tbl[i].d1;
         check($sformatf("vec%0d valid1", i), 32'(rd_valid1), 32'(tbl[i].vld));
         check($sformatf("vec%0d data1", i), 32'(rd_data1), 32'(last1));
         check($sformatf("vec%0d col1", i), 32'(collision1), 32'(tbl[i].vld & tbl[i].col));
         check($sformatf("vec%0d pulse0 one cycle", i), 32'(rd_valid0), 32'd0);
         check($sformatf("vec%0d hold data0", i), 32'(rd_data0), 32'(last0));
      end

      // Fill 0..19 with small pseudo-random values, then stream them back.
      for (int a = 0; a < 20; a++) begin
         model[a] = 16'($urandom_range(0, 254));
         en      = 1'b1;
         wr_en   = 1'b1;
         wr_addr = a[4:0];
         wr_data = model[a];
         wr_be   = 2'b11;
         @(posedge clk); #1;
      end
      en      = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 16'h5A5A;
      wr_be   = 2'b11;
      model[5] = 16'h5A5A;
      @(posedge clk); #1;
      idle();
      read_stream("rand", 20);

      // Reset with a read in flight (dut1 result still in its pipeline).
      en      = 1'b1;
      rd_en   = 1'b1;
      rd_addr = 5'd5;
      @(posedge clk); #1;
      idle();
      check("inflight valid0 before reset", 32'(rd_valid0), 32'd1);
      check("inflight data0 before reset", 32'(rd_data0), 32'h5A5A);
      #1 rst = 1'b0;
      #1;
      check("inflight rst valid0", 32'(rd_valid0), 32'd0);
      check("inflight rst valid1", 32'(rd_valid1), 32'd0);
      check("inflight rst data0", 32'(rd_data0), 32'd0);
      check("inflight rst data1", 32'(rd_data1), 32'd0);
      check("inflight rst ready0", 32'(ready0), 32'd0);
      check("inflight rst ready1", 32'(ready1), 32'd0);
      vseen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (rd_valid0 || rd_valid1) vseen = 1'b1;
      end
      check("inflight read discarded", 32'(vseen), 32'd0);

      // First release, then reset again with the clear counter at 10.
      @(negedge clk); #2 rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("mid-init ready0", 32'(ready0), 32'd0);
      rst = 1'b0;
      #1;
      check("mid-init rst ready0", 32'(ready0), 32'd0);
      check("mid-init rst ready1", 32'(ready1), 32'd0);
      @(negedge clk); #2 rst = 1'b1;
      wait_ready("restart");

      for (int a = 0; a < 32; a++) model[a] = 16'h0000;
      read_stream("reclear", 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
